writeback_arbiter: RTL and testbench

- Producer end of the register-forwarding interface.
- Merges in-order pipeline results from the mem stage with out-of-order-in-time external load returns into a single registered writeback port (`wreg_en_wb`/`rd_wb`/`wreg_data_wb`), which feeds both the register file write port and the dc-stage bypass network.
- Buffers load returns that collide with pipeline writes.
- Keeps a per-register pending scoreboard of outstanding external loads so the hazard logic can stall dependent instructions.

---
 rtl/writeback_arbiter_pkg.sv | 20 ++
 rtl/writeback_arbiter_ret_fifo.sv | 44 ++++
 rtl/writeback_arbiter.sv | 143 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the writeback arbiter: bus widths, control encodings
// and the default load-queue depth.
package writeback_arbiter_pkg;

   localparam int XLEN_BUS         = 64;
   localparam int REG_INDEX_BUS    = 5;
   localparam int LQ_DEPTH_DEFAULT = 4;

   localparam logic W_REG_EN       = 1'b1;
   localparam logic FLUSH_PIPELINE = 1'b1;
   localparam logic CANCEL_INSTR   = 1'b1;

   localparam logic [REG_INDEX_BUS-1:0] ZERO = '0;

   // Control-level qualification of a mem-stage write; the rd != x0 test is done by the caller.
   function automatic logic pipe_write_ok(input logic en, input logic flush, input logic cancel);
      return (en == W_REG_EN) && (flush != FLUSH_PIPELINE) && (cancel != CANCEL_INSTR);
   endfunction

endpackage

// File: rtl/writeback_arbiter_ret_fifo.sv
// Load-return buffer: synchronous first-word-fall-through FIFO with
// extra-MSB wrap-around pointers and a one-cycle clear.
module wb_ret_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 69
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   // Same slot, opposite lap: the writer is exactly one lap ahead.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges mem-stage results and external load returns into one registered
// writeback port, and tracks outstanding loads in a per-register scoreboard.
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int XLEN      = XLEN_BUS,
   parameter int REG_IDX_W = REG_INDEX_BUS,
   parameter int LQ_DEPTH  = LQ_DEPTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wreg_en_mem,
   input  logic [REG_IDX_W-1:0] rd_mem,
   input  logic [XLEN-1:0]      wreg_data_mem,
   input  logic                 flush_mem,
   input  logic                 cancel_instr_mem,
   input  logic                 ld_issue_valid,
   input  logic [REG_IDX_W-1:0] ld_issue_rd,
   output logic                 ld_issue_ready,
   input  logic                 ld_ret_valid,
   input  logic [REG_IDX_W-1:0] ld_ret_rd,
   input  logic [XLEN-1:0]      ld_ret_data,
   output logic                 ld_ret_ready,
   input  logic                 ld_kill,
   output logic                 wreg_en_wb,
   output logic [REG_IDX_W-1:0] rd_wb,
   output logic [XLEN-1:0]      wreg_data_wb,
   output logic [31:0]          pending_mask,
   output logic                 ld_busy
);

   localparam int CW = $clog2(LQ_DEPTH) + 1;

   logic                      pipe_valid, ret_acc, ret_drop, ret_keep, ret_direct;
   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic                      issue_fire, load_wb;
   logic [REG_IDX_W+XLEN-1:0] fifo_dout;
   logic [REG_IDX_W-1:0]      load_rd;
   logic [XLEN-1:0]           load_data;

   logic [CW-1:0]        outstanding_q, outstanding_d;
   logic [CW-1:0]        drop_cnt_q, drop_cnt_d;
   logic [31:0]          pending_q, pending_d;
   logic                 wb_en_q, wb_en_d;
   logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]      wb_data_q, wb_data_d;
   logic                 busy_q, busy_d;

   wb_ret_fifo #(
      .DEPTH (LQ_DEPTH),
      .WIDTH (REG_IDX_W + XLEN)
   ) u_ret_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (ld_kill),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .din_i   ({ld_ret_rd, ld_ret_data}),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign ld_issue_ready = (outstanding_q < CW'(LQ_DEPTH)) && !pending_q[ld_issue_rd];
   assign ld_ret_ready   = !fifo_full || (drop_cnt_q != '0);

   always_comb begin
      pipe_valid = pipe_write_ok(wreg_en_mem, flush_mem, cancel_instr_mem) &&
                   (rd_mem != REG_IDX_W'(ZERO));
      ret_acc    = ld_ret_valid && ld_ret_ready;
      ret_drop   = ret_acc && (drop_cnt_q != '0);
      ret_keep   = ret_acc && !ret_drop;
      // A killed buffer is not drained; its contents are discarded by the clear.
      fifo_pop   = !pipe_valid && !fifo_empty && !ld_kill;
      ret_direct = ret_keep && fifo_empty && !pipe_valid;
      fifo_push  = ret_keep && !ret_direct;
      issue_fire = ld_issue_valid && ld_issue_ready && !ld_kill;
      load_wb    = fifo_pop || ret_direct;
      load_rd    = fifo_pop ? fifo_dout[XLEN +: REG_IDX_W] : ld_ret_rd;
      load_data  = fifo_pop ? fifo_dout[XLEN-1:0] : ld_ret_data;

      wb_en_d   = 1'b0;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      if (pipe_valid) begin
         wb_en_d   = 1'b1;
         wb_rd_d   = rd_mem;
         wb_data_d = wreg_data_mem;
      end else if (load_wb) begin
         wb_en_d   = (load_rd != REG_IDX_W'(ZERO));
         wb_rd_d   = load_rd;
         wb_data_d = load_data;
      end

      pending_d = pending_q;
      if (load_wb) pending_d[load_rd] = 1'b0;
      if (issue_fire && (ld_issue_rd != REG_IDX_W'(ZERO))) pending_d[ld_issue_rd] = 1'b1;

      outstanding_d = outstanding_q;
      case ({issue_fire, load_wb})
         2'b10:   outstanding_d = outstanding_q + CW'(1);
         2'b01:   outstanding_d = outstanding_q - CW'(1);
         default: outstanding_d = outstanding_q;
      endcase
      drop_cnt_d = ret_drop ? drop_cnt_q - CW'(1) : drop_cnt_q;

      if (ld_kill) begin
         pending_d     = '0;
         drop_cnt_d    = outstanding_q - CW'(ret_keep);
         outstanding_d = '0;
      end

      // Buffered entries are still counted as outstanding, so this also covers a non-empty buffer.
      busy_d = (outstanding_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         pending_q     <= '0;
         wb_en_q       <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         busy_q        <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         pending_q     <= pending_d;
         wb_en_q       <= wb_en_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         busy_q        <= busy_d;
      end
   end

   assign wreg_en_wb   = wb_en_q;
   assign rd_wb        = wb_rd_q;
   assign wreg_data_wb = wb_data_q;
   assign pending_mask = pending_q;
   assign ld_busy      = busy_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_writeback_arbiter;

   localparam int LQ = 4;

   logic        clk;
   logic        rst;
   logic        wreg_en_mem;
   logic [4:0]  rd_mem;
   logic [63:0] wreg_data_mem;
   logic        flush_mem;
   logic        cancel_instr_mem;
   logic        ld_issue_valid;
   logic [4:0]  ld_issue_rd;
   logic        ld_issue_ready;
   logic        ld_ret_valid;
   logic [4:0]  ld_ret_rd;
   logic [63:0] ld_ret_data;
   logic        ld_ret_ready;
   logic        ld_kill;
   logic        wreg_en_wb;
   logic [4:0]  rd_wb;
   logic [63:0] wreg_data_wb;
   logic [31:0] pending_mask;
   logic        ld_busy;

   writeback_arbiter dut (
      .clk              (clk),
      .rst              (rst),
      .wreg_en_mem      (wreg_en_mem),
      .rd_mem           (rd_mem),
      .wreg_data_mem    (wreg_data_mem),
      .flush_mem        (flush_mem),
      .cancel_instr_mem (cancel_instr_mem),
      .ld_issue_valid   (ld_issue_valid),
      .ld_issue_rd      (ld_issue_rd),
      .ld_issue_ready   (ld_issue_ready),
      .ld_ret_valid     (ld_ret_valid),
      .ld_ret_rd        (ld_ret_rd),
      .ld_ret_data      (ld_ret_data),
      .ld_ret_ready     (ld_ret_ready),
      .ld_kill          (ld_kill),
      .wreg_en_wb       (wreg_en_wb),
      .rd_wb            (rd_wb),
      .wreg_data_wb     (wreg_data_wb),
      .pending_mask     (pending_mask),
      .ld_busy          (ld_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outstanding loads as a count, the buffer as a queue of {rd,data}.
   bit          m_started = 0;
   logic        m_en;
   logic [4:0]  m_rd;
   logic [63:0] m_data;
   logic [31:0] m_pend;
   int          m_out;
   int          m_drop;
   logic [68:0] m_buf [$];

   task automatic model_step();
      bit          pipe, rready, iready, acc, dropped, keep, issue, lwb;
      logic [4:0]  lrd;
      logic [63:0] ldat;
      if (rst) begin
         m_en = 0; m_rd = '0; m_data = '0; m_pend = '0;
         m_out = 0; m_drop = 0; m_buf.delete();
         return;
      end
      pipe    = wreg_en_mem && !flush_mem && !cancel_instr_mem && (rd_mem != 5'd0);
      rready  = (m_buf.size() < LQ) || (m_drop > 0);
      iready  = (m_out < LQ) && !m_pend[ld_issue_rd];
      acc     = ld_ret_valid && rready;
      dropped = acc && (m_drop > 0);
      keep    = acc && !dropped;
      issue   = ld_issue_valid && iready && !ld_kill;
      lwb     = 0;
      lrd     = '0;
      ldat    = '0;
      if (pipe) begin
         chk("pipe_hits_pending", {63'd0, m_pend[rd_mem]}, 64'd0);
         m_en = 1; m_rd = rd_mem; m_data = wreg_data_mem;
         if (keep) m_buf.push_back({ld_ret_rd, ld_ret_data});
      end else begin
         m_en = 0;
         if (m_buf.size() > 0 && !ld_kill) begin
            {lrd, ldat} = m_buf.pop_front();
            lwb = 1;
            if (keep) m_buf.push_back({ld_ret_rd, ld_ret_data});
         end else if (keep && m_buf.size() == 0) begin
            lrd = ld_ret_rd; ldat = ld_ret_data; lwb = 1;
         end else if (keep) begin
            m_buf.push_back({ld_ret_rd, ld_ret_data});
         end
      end
      if (lwb) begin
         m_en = (lrd != 5'd0); m_rd = lrd; m_data = ldat;
         m_pend[lrd] = 1'b0;
      end
      if (issue && ld_issue_rd != 5'd0) m_pend[ld_issue_rd] = 1'b1;
      if (ld_kill) begin
         m_drop = m_out - int'(keep);
         m_out  = 0;
         m_pend = '0;
         m_buf.delete();
      end else begin
         m_out = m_out + int'(issue) - int'(lwb);
         if (dropped) m_drop--;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
      m_started = 1;
   end

   initial forever begin
      @(negedge clk);
      if (m_started) begin
         chk("wreg_en_wb", {63'd0, wreg_en_wb}, {63'd0, m_en});
         if (m_en) begin
            chk("rd_wb", {59'd0, rd_wb}, {59'd0, m_rd});
            chk("wreg_data_wb", wreg_data_wb, m_data);
         end
         chk("pending_mask", {32'd0, pending_mask}, {32'd0, m_pend});
         chk("ld_busy", {63'd0, ld_busy}, {63'd0, (m_out != 0) || (m_buf.size() != 0)});
         chk("ld_ret_ready", {63'd0, ld_ret_ready},
             {63'd0, (m_buf.size() < LQ) || (m_drop > 0)});
         chk("ld_issue_ready", {63'd0, ld_issue_ready},
             {63'd0, (m_out < LQ) && !m_pend[ld_issue_rd]});
      end
   end

   task automatic idle();
      wreg_en_mem = 0; rd_mem = '0; wreg_data_mem = '0;
      flush_mem = 0; cancel_instr_mem = 0;
      ld_issue_valid = 0; ld_issue_rd = '0;
      ld_ret_valid = 0; ld_ret_rd = '0; ld_ret_data = '0;
      ld_kill = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic [4:0] r, input logic [63:0] d);
      wreg_en_mem = 1; rd_mem = r; wreg_data_mem = d;
   endtask

   task automatic issue(input logic [4:0] r);
      ld_issue_valid = 1; ld_issue_rd = r;
   endtask

   task automatic ret(input logic [4:0] r, input logic [63:0] d);
      ld_ret_valid = 1; ld_ret_rd = r; ld_ret_data = d;
   endtask

   task automatic chk_wb(input string name, input logic [4:0] r, input logic [63:0] d);
      chk({name, "_en"}, {63'd0, wreg_en_wb}, 64'd1);
      chk({name, "_rd"}, {59'd0, rd_wb}, {59'd0, r});
      chk({name, "_data"}, wreg_data_wb, d);
   endtask

   // Issue x1..x4, then return them under a busy pipeline so all four are buffered.
   task automatic fill_buffer(input logic [63:0] base);
      for (int i = 0; i < 4; i++) begin
         idle(); issue(5'(i + 1)); tick();
         $display("issue load x%0d", i + 1);
      end
      for (int i = 0; i < 4; i++) begin
         idle(); pipe(5'(10 + i), 64'(100 + i)); ret(5'(i + 1), base + 64'(i)); tick();
         $display("pipe x%0d with buffered return x%0d", 10 + i, i + 1);
         chk_wb("fill_pipe", 5'(10 + i), 64'(100 + i));
      end
      idle(); #1;
      chk("buffer_full_ret_ready", {63'd0, ld_ret_ready}, 64'd0);
   endtask

   initial begin
      rst = 1;
      idle();
      tick(); tick();
      chk("reset_en", {63'd0, wreg_en_wb}, 64'd0);
      chk("reset_rd", {59'd0, rd_wb}, 64'd0);
      chk("reset_data", wreg_data_wb, 64'd0);
      chk("reset_pending", {32'd0, pending_mask}, 64'd0);
      chk("reset_busy", {63'd0, ld_busy}, 64'd0);
      rst = 0;
      tick();

      // Plain pipeline writes and suppressed ones
      pipe(5'd5, 64'h11); tick();
      $display("pipe write x5=0x11");
      chk_wb("pipe_x5", 5'd5, 64'h11);
      idle(); pipe(5'd6, 64'h22); flush_mem = 1; tick();
      $display("flushed pipe write x6");
      chk("flush_no_write", {63'd0, wreg_en_wb}, 64'd0);
      idle(); pipe(5'd0, 64'h33); tick();
      $display("pipe write to x0");
      chk("x0_no_write", {63'd0, wreg_en_wb}, 64'd0);
      idle(); pipe(5'd6, 64'h44); cancel_instr_mem = 1; tick();
      $display("cancelled pipe write x6");
      chk("cancel_no_write", {63'd0, wreg_en_wb}, 64'd0);

      // Single load, direct return
      idle(); issue(5'd7); #1;
      chk("issue_x7_ready", {63'd0, ld_issue_ready}, 64'd1);
      tick();
      $display("issue load x7");
      chk("pending7_set", {32'd0, pending_mask}, 64'h80);
      chk("busy_after_issue", {63'd0, ld_busy}, 64'd1);
      idle(); tick();
      chk("pending7_hold", {32'd0, pending_mask}, 64'h80);
      ret(5'd7, 64'hAA); tick();
      $display("direct return x7=0xAA");
      chk_wb("direct_x7", 5'd7, 64'hAA);
      chk("pending7_clear", {32'd0, pending_mask}, 64'd0);
      chk("busy_after_ret", {63'd0, ld_busy}, 64'd0);

      // Collision: return buffered behind a pipeline write
      idle(); issue(5'd7); tick();
      idle(); pipe(5'd3, 64'h33); ret(5'd7, 64'hAA); tick();
      $display("pipe x3=0x33 colliding with return x7=0xAA");
      chk_wb("collide_pipe_x3", 5'd3, 64'h33);
      chk("collide_x7_still_pending", {32'd0, pending_mask}, 64'h80);
      idle(); tick();
      $display("queued return x7 drains");
      chk_wb("collide_ret_x7", 5'd7, 64'hAA);

      // Two full rounds through the buffer, with ready back-pressure
      for (int rnd = 0; rnd < 2; rnd++) begin
         fill_buffer(64'hA0 + 64'(16 * rnd));
         issue(5'd5); #1;
         chk("issue_ready_lq_full", {63'd0, ld_issue_ready}, 64'd0);
         issue(5'd2); #1;
         chk("issue_ready_pending", {63'd0, ld_issue_ready}, 64'd0);
         idle();
         for (int i = 0; i < 4; i++) begin
            tick();
            $display("drain buffered return x%0d", i + 1);
            chk_wb("drain", 5'(i + 1), 64'hA0 + 64'(16 * rnd) + 64'(i));
         end
         tick();
         chk("drain_idle", {63'd0, wreg_en_wb}, 64'd0);
         chk("drain_not_busy", {63'd0, ld_busy}, 64'd0);
      end

      // Kill with three loads in flight; kill-cycle issue ignored
      for (int i = 1; i <= 3; i++) begin
         idle(); issue(5'(i)); tick();
      end
      idle(); ld_kill = 1; issue(5'd8); tick();
      $display("kill with three loads outstanding");
      chk("kill_mask", {32'd0, pending_mask}, 64'd0);
      chk("kill_busy", {63'd0, ld_busy}, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         idle(); ret(5'(i), 64'hDEAD); #1;
         chk("drop_ret_ready", {63'd0, ld_ret_ready}, 64'd1);
         tick();
         $display("stale return x%0d dropped", i);
         chk("drop_no_write", {63'd0, wreg_en_wb}, 64'd0);
      end
      idle(); issue(5'd9); tick();
      chk("fresh_pending9", {32'd0, pending_mask}, 64'h200);
      idle(); ret(5'd9, 64'h99); tick();
      $display("fresh return x9=0x99 after kill");
      chk_wb("fresh_x9", 5'd9, 64'h99);

      // Reset with a full buffer and a return on the wire
      idle(); tick();
      fill_buffer(64'hC0);
      rst = 1; ret(5'd1, 64'hBAD); tick();
      $display("reset with full buffer");
      chk("rst_en", {63'd0, wreg_en_wb}, 64'd0);
      chk("rst_rd", {59'd0, rd_wb}, 64'd0);
      chk("rst_data", wreg_data_wb, 64'd0);
      chk("rst_pending", {32'd0, pending_mask}, 64'd0);
      chk("rst_busy", {63'd0, ld_busy}, 64'd0);
      rst = 0; idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_write", {63'd0, wreg_en_wb}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
